control_timing_unit: RTL

//  Consumer of the sequencer's one-hot timing vector T[15:0] (4-bit counter + 4-16 decoder).

---
 rtl/control_timing_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/control_timing_unit.sv
// Control timing unit: turns the sequencer's one-hot T vector into fetch/decode/indirect
// controls and end-of-instruction counter clears. Optional interrupt cycle under INTERRUPT_EN.
module control_timing_unit #(
  parameter logic [2:0] BUS_PC  = 3'd2,
  parameter logic [2:0] BUS_IR  = 3'd5,
  parameter logic [2:0] BUS_MEM = 3'd7
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic [15:0] T,
  input  logic [15:0] IR,
  input  logic        START,
`ifdef INTERRUPT_EN
  input  logic        INT_REQ,
  input  logic        IEN_SET,
  input  logic        IEN_CLR,
  output logic        INT_CYCLE,
  output logic        AR_CLR,
  output logic        PC_CLR,
  output logic        TR_LD,
  output logic        MEM_WR,
`endif
  output logic        SC_CLR,
  output logic        AR_LD,
  output logic        IR_LD,
  output logic        PC_INC,
  output logic        MEM_RD,
  output logic [2:0]  BUS_SEL,
  output logic [7:0]  D,
  output logic        I_FLAG,
  output logic        RUN,
  output logic        T_ERR
);

  logic s;
  logic t_onehot, active, hlt, latch_dec, end_step;
  logic unused;

  assign unused   = ^IR[11:1];
  assign t_onehot = (T != 16'd0) && ((T & (T - 16'd1)) == 16'd0);
  assign active   = s && !T_ERR && t_onehot;
  assign hlt      = active && T[3] && D[7] && !I_FLAG && IR[0];
  assign RUN      = s;
  assign end_step = (T[4] && (D[3] || D[4])) ||
                    (T[5] && (D[0] || D[1] || D[2] || D[5])) ||
                    (T[6] && D[6]) || (|T[15:7]);

`ifdef INTERRUPT_EN
  localparam logic [2:0] BUS_TR = 3'd6;
  logic ien, r;
  assign INT_CYCLE = r;
  assign latch_dec = active && T[2] && !r;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      ien <= 1'b0;
      r   <= 1'b0;
    end else begin
      if (r && active && T[2])
        r <= 1'b0;
      else if (s && ien && INT_REQ && !(T[0] || T[1] || T[2]))
        r <= 1'b1;
      if (IEN_CLR || (r && active && T[2]))
        ien <= 1'b0;
      else if (IEN_SET)
        ien <= 1'b1;
    end
  end
`else
  assign latch_dec = active && T[2];
`endif

  always_ff @(posedge CLK) begin
    if (CLR) begin
      s      <= 1'b0;
      D      <= 8'h00;
      I_FLAG <= 1'b0;
      T_ERR  <= 1'b0;
    end else begin
      if (s && !t_onehot)
        T_ERR <= 1'b1;
      if (hlt)
        s <= 1'b0;
      else if (START)
        s <= 1'b1;
      if (latch_dec) begin
        D      <= 8'h01 << IR[14:12];
        I_FLAG <= IR[15];
      end
    end
  end

  always_comb begin
    SC_CLR  = 1'b0;
    AR_LD   = 1'b0;
    IR_LD   = 1'b0;
    PC_INC  = 1'b0;
    MEM_RD  = 1'b0;
    BUS_SEL = 3'd0;
`ifdef INTERRUPT_EN
    AR_CLR  = 1'b0;
    PC_CLR  = 1'b0;
    TR_LD   = 1'b0;
    MEM_WR  = 1'b0;
`endif
    // A malformed T is never decoded: park the sequencer even before T_ERR latches.
    if (!active) begin
      SC_CLR = 1'b1;
    end else if (T[0] || T[1] || T[2]) begin
`ifdef INTERRUPT_EN
      if (r) begin
        if (T[0]) begin
          AR_CLR  = 1'b1;
          TR_LD   = 1'b1;
          BUS_SEL = BUS_PC;
        end else if (T[1]) begin
          MEM_WR  = 1'b1;
          PC_CLR  = 1'b1;
          BUS_SEL = BUS_TR;
        end else begin
          PC_INC  = 1'b1;
          SC_CLR  = 1'b1;
        end
      end else
`endif
      begin
        if (T[0]) begin
          BUS_SEL = BUS_PC;
          AR_LD   = 1'b1;
        end else if (T[1]) begin
          BUS_SEL = BUS_MEM;
          MEM_RD  = 1'b1;
          IR_LD   = 1'b1;
          PC_INC  = 1'b1;
        end else begin
          BUS_SEL = BUS_IR;
          AR_LD   = 1'b1;
        end
      end
    end else if (T[3]) begin
      if (D[7]) begin
        SC_CLR = 1'b1;
      end else if (I_FLAG) begin
        BUS_SEL = BUS_MEM;
        MEM_RD  = 1'b1;
        AR_LD   = 1'b1;
      end
    end else if (end_step) begin
      SC_CLR = 1'b1;
    end
  end

endmodule
